instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
Parametrised successor to the UART-loaded instruction ROM. It runs on a single clock domain, with the UART receiver oversampled directly on i_clk and no divided clock. Received bytes are assembled into WORD_BYTES-wide instruction words and written to internal block RAM of depth 2**ADDR_W. A deterministic idle-timeout end-of-load FSM replaces the old UART/FIFO "clear" heuristic. The core fetch stage reads through a 1-cycle-latency synchronous port.

Parameters:
CLK_FREQ, 100000000, i_clk frequency in Hz
BAUD_RATE, 115200, UART bit rate; CLK_DIV = CLK_FREQ/BAUD_RATE (integer, must be ≥ 4)
WORD_BYTES, 2, bytes per instruction word; WORD_W = 8*WORD_BYTES
ADDR_W, 8, memory address width; DEPTH = 2**ADDR_W
MSB_FIRST, 1, 1: first received byte of a word fills bits [WORD_W-1 -: 8]; 0: first byte fills [7:0]
IDLE_BITS, 20, end-of-load timeout, in bit times after the last accepted byte

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx  in  1  UART serial input, idle high, asynchronous to i_clk
i_reload  in  1  1-cycle pulse: restart loading (DONE -> WAIT)
en_read  in  1  read enable
i_addr_read  in  ADDR_W  read address
o_instr_read  out  WORD_W  read data, registered
o_load_done  out  1  level: load complete
o_max_addr  out  ADDR_W  address of last written word (0 if none)
o_word_count  out  ADDR_W+1  number of words written
o_overflow  out  1  sticky: word dropped because memory full
o_frame_err  out  1  sticky: stop bit sampled low

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSMs to idle, counters 0. Memory contents are not reset.
- RX front end: i_rx passes through a 2-flop synchroniser; its reset value is 1.
- RX FSM: R_IDLE -> R_START on synchronised 1->0 edge.
  - R_START: wait CLK_DIV/2 clocks, resample. If high (glitch), go to R_IDLE with no error. If low, go to R_DATA.
  - R_DATA: sample 8 bits LSB-first, one every CLK_DIV clocks.
  - R_STOP: sample after CLK_DIV clocks. If high, assert byte_valid for 1 cycle. If low, set o_frame_err, discard the byte, and wait for the line to return high before R_IDLE.
- Assembler: byte index 0..WORD_BYTES-1 places each byte per MSB_FIRST.
  - On the last byte, write the word at wr_ptr in the same cycle as byte_valid, then increment wr_ptr and o_word_count.
  - o_max_addr = o_word_count-1 (truncated to ADDR_W) once o_word_count > 0.
- Full: when o_word_count == DEPTH, further completed words are dropped and o_overflow is set. wr_ptr never wraps.
- Load FSM:
  - L_WAIT -> L_LOAD on the first accepted byte.
  - In L_LOAD, the idle counter resets on every byte_valid and increments otherwise.
  - When the counter reaches IDLE_BITS*CLK_DIV-1 -> L_DONE. o_load_done is 1 exactly in L_DONE, starting the cycle after the transition.
- Partial word at timeout: remaining bytes are zero-padded and the word is written (counts as a word) on the L_LOAD -> L_DONE transition cycle.
- In L_DONE: RX keeps running (so o_frame_err can still set), but bytes are not assembled.
- i_reload:
  - In L_DONE: go to L_WAIT and clear wr_ptr, o_word_count, byte index, o_overflow and o_frame_err. Memory is kept.
  - In L_WAIT or L_LOAD: ignored.
- Read port:
  - If en_read, o_instr_read <= mem[i_addr_read] on the next edge; otherwise it holds.
  - Reads are allowed in any load state.
  - Same-cycle read/write of one address returns old data (read-first).
  - Addresses ≥ o_word_count return stale contents; no checking is done.
- A line held low forever: R_START/R_DATA complete, stop bit low -> frame error. No lock-up.

Decomposition:
- Shared package (instr_loader_pkg):
  - RX state enum (R_IDLE, R_START, R_DATA, R_STOP)
  - Load state enum (L_WAIT, L_LOAD, L_DONE)
  - Helper function clog2 for counter widths
- One sub-module, uart_rx_core: synchroniser, RX FSM, baud counter. Outputs are byte[7:0], byte_valid and frame_err pulse.
- Assembler, load FSM and memory stay in the top level; memory is coded as an inferable BRAM.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (CLK_DIV=10), IDLE_BITS=20, ADDR_W=4, WORD_BYTES=2, MSB_FIRST=1.
1. Send 0x12,0x34,0xAB,0xCD, then idle 200 clocks -> mem[0]=0x1234, mem[1]=0xABCD, o_word_count=2, o_max_addr=1; o_load_done rises ~200 clocks after the last stop bit.
2. Then en_read=1, i_addr_read=1 -> o_instr_read=0xABCD on the next cycle; with en_read=0 the value holds.
3. Send 3 bytes 0x11,0x22,0x33, then idle -> mem[1]=0x3300, o_word_count=2, o_load_done=1.
4. Send 34 bytes (17 words) -> o_word_count=16, o_max_addr=15, o_overflow=1; mem[15] = the 16th word.
5. Drive a byte with stop bit low, then a valid byte pair -> o_frame_err=1, the bad byte is discarded, and the next pair is assembled correctly. Also apply a 3-clock low glitch on i_rx -> no byte and no error.
6. From L_DONE, pulse i_reload, send 0xBEEF -> o_load_done=0 during reload, mem[0]=0xBEEF, flags cleared. Assert i_rst_n mid-byte -> all outputs 0 immediately, and the next clean frame is received correctly.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and helpers for the UART instruction loader
//
// Purpose: state encodings for the UART receiver and the load FSM, plus a
//          constant-evaluable clog2 used to size counters.
// Ports:   none (package).
package instr_loader_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_WAIT,
    L_LOAD,
    L_DONE
  } load_state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/instr_loader_rx.sv
// rtl/instr_loader_rx.sv - oversampled UART receiver core (8N1)
//
// Purpose: synchronises i_rx, detects the start edge, samples 8 data bits
//          LSB-first at bit centres and checks the stop bit.
// Ports:   i_clk, i_rst_n   clock / async active-low reset
//          i_rx             raw serial input, idle high
//          o_byte           received byte, valid while o_byte_valid is high
//          o_byte_valid     1-cycle pulse per good frame
//          o_frame_err      1-cycle pulse when the stop bit is sampled low
module uart_rx_core
  import instr_loader_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);

  rx_state_t        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    sync1_d      = i_rx;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      R_IDLE: begin
        // A falling edge needs the line to have been high first, so after a
        // low stop bit we naturally wait here until the line recovers.
        if (prev_q && !sync2_q) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = R_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= R_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = byte_valid_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART-loaded instruction memory with idle-timeout end of load
//
// Purpose: assembles UART bytes into WORD_W-bit words, writes them into a
//          block RAM, ends the load after IDLE_BITS quiet bit times, and
//          serves a registered read port to the fetch stage.
// Ports:   i_clk, i_rst_n   clock / async active-low reset
//          i_rx             UART serial input
//          i_reload         pulse: restart loading from L_DONE
//          en_read          read enable
//          i_addr_read      read address
//          o_instr_read     registered read data
//          o_load_done      high while in L_DONE
//          o_max_addr       address of last written word
//          o_word_count     number of words written
//          o_overflow       sticky: completed word dropped, memory full
//          o_frame_err      sticky: stop bit sampled low
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_BITS  = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx,
  input  logic                    i_reload,
  input  logic                    en_read,
  input  logic [ADDR_W-1:0]       i_addr_read,
  output logic [8*WORD_BYTES-1:0] o_instr_read,
  output logic                    o_load_done,
  output logic [ADDR_W-1:0]       o_max_addr,
  output logic [ADDR_W:0]         o_word_count,
  output logic                    o_overflow,
  output logic                    o_frame_err
);

  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int WORD_W  = 8 * WORD_BYTES;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int IDLE_W  = clog2(IDLE_BITS * CLK_DIV);
  localparam int BIDX_W  = clog2(WORD_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_BITS * CLK_DIV - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx_core #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_valid),
    .o_frame_err  (rx_frame_err)
  );

  load_state_t       load_state_q, load_state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] word_buf_q, word_buf_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic [WORD_W-1:0] instr_read_q, instr_read_d;

  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] wr_data;
  logic              commit;
  logic              we;

  logic [WORD_W-1:0] mem [DEPTH];

  // Word buffer with the incoming byte dropped into its slot.
  always_comb begin
    word_next = word_buf_q;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byte_idx_q == BIDX_W'(k)) begin
        if (MSB_FIRST != 0) word_next[(WORD_BYTES-1-k)*8 +: 8] = rx_byte;
        else                word_next[k*8 +: 8]                = rx_byte;
      end
    end
  end

  always_comb begin
    load_state_d = load_state_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    idle_cnt_d   = idle_cnt_q;
    overflow_d   = overflow_q;
    commit       = 1'b0;
    wr_data      = word_next;
    we           = 1'b0;

    case (load_state_q)
      L_WAIT, L_LOAD: begin
        if (rx_valid) begin
          load_state_d = L_LOAD;
          idle_cnt_d   = '0;
          if (byte_idx_q == BIDX_LAST) begin
            commit     = 1'b1;
            byte_idx_d = '0;
            word_buf_d = '0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            word_buf_d = word_next;
          end
        end else if (load_state_q == L_LOAD) begin
          if (idle_cnt_q == IDLE_LAST) begin
            load_state_d = L_DONE;
            // Unfilled byte slots are still zero, which is the padding.
            if (byte_idx_q != '0) begin
              commit     = 1'b1;
              wr_data    = word_buf_q;
              byte_idx_d = '0;
              word_buf_d = '0;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      L_DONE: begin
        if (i_reload) begin
          load_state_d = L_WAIT;
          word_count_d = '0;
          byte_idx_d   = '0;
          word_buf_d   = '0;
          idle_cnt_d   = '0;
          overflow_d   = 1'b0;
        end
      end
      default: load_state_d = L_WAIT;
    endcase

    // Write pointer is the word count itself, so a full memory never wraps.
    if (commit) begin
      if (word_count_q == FULL_COUNT) begin
        overflow_d = 1'b1;
      end else begin
        we           = 1'b1;
        word_count_d = word_count_q + 1'b1;
      end
    end

    frame_err_d = ((load_state_q == L_DONE && i_reload) ? 1'b0 : frame_err_q) | rx_frame_err;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      load_state_q <= L_WAIT;
      word_count_q <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      idle_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      load_state_q <= load_state_d;
      word_count_q <= word_count_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      idle_cnt_q   <= idle_cnt_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Block RAM: write port from the assembler, registered read port below.
  always_ff @(posedge i_clk) begin
    if (we) mem[word_count_q[ADDR_W-1:0]] <= wr_data;
  end

  // Read-first: a same-edge write is not visible through this register.
  assign instr_read_d = en_read ? mem[i_addr_read] : instr_read_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) instr_read_q <= '0;
    else          instr_read_q <= instr_read_d;
  end

  assign o_instr_read = instr_read_q;
  assign o_load_done  = (load_state_q == L_DONE);
  assign o_word_count = word_count_q;
  assign o_max_addr   = (word_count_q == '0) ? '0 : word_count_q[ADDR_W-1:0] - 1'b1;
  assign o_overflow   = overflow_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_rx;
  logic        i_reload;
  logic        en_read;
  logic [3:0]  i_addr_read;
  logic [15:0] o_instr_read;
  logic        o_load_done;
  logic [3:0]  o_max_addr;
  logic [4:0]  o_word_count;
  logic        o_overflow;
  logic        o_frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_loader #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .WORD_BYTES (2),
    .ADDR_W     (4),
    .MSB_FIRST  (1),
    .IDLE_BITS  (20)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .i_reload     (i_reload),
    .en_read      (en_read),
    .i_addr_read  (i_addr_read),
    .o_instr_read (o_instr_read),
    .o_load_done  (o_load_done),
    .o_max_addr   (o_max_addr),
    .o_word_count (o_word_count),
    .o_overflow   (o_overflow),
    .o_frame_err  (o_frame_err)
  );

  typedef struct {
    int          phase;
    logic        en;
    logic [3:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(10);
    end
    i_rx = stop_bit;
    tick(10);
    i_rx = 1'b1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!o_load_done && n < 600) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, o_load_done}, 32'd1);
  endtask

  task automatic pulse_reload();
    i_reload = 1'b1;
    tick(1);
    i_reload = 1'b0;
  endtask

  task automatic apply_reads(input int phase);
    foreach (vecs[i]) begin
      if (vecs[i].phase == phase) begin
        en_read     = vecs[i].en;
        i_addr_read = vecs[i].addr;
        tick(1);
        check($sformatf("read_p%0d_v%0d", phase, i), {16'd0, o_instr_read}, {16'd0, vecs[i].exp});
      end
    end
    en_read = 1'b0;
  endtask

  initial begin
    int n;

    vecs.push_back('{1, 1'b1, 4'd1,  16'hABCD});
    vecs.push_back('{1, 1'b0, 4'd0,  16'hABCD});
    vecs.push_back('{1, 1'b0, 4'd7,  16'hABCD});
    vecs.push_back('{1, 1'b1, 4'd0,  16'h1234});
    vecs.push_back('{1, 1'b0, 4'd1,  16'h1234});
    vecs.push_back('{3, 1'b1, 4'd0,  16'h1122});
    vecs.push_back('{3, 1'b1, 4'd1,  16'h3300});
    vecs.push_back('{4, 1'b1, 4'd15, 16'h1E1F});
    vecs.push_back('{4, 1'b1, 4'd0,  16'h0001});
    vecs.push_back('{4, 1'b1, 4'd14, 16'h1C1D});
    vecs.push_back('{5, 1'b1, 4'd0,  16'hA55A});
    vecs.push_back('{6, 1'b1, 4'd0,  16'hBEEF});
    vecs.push_back('{7, 1'b1, 4'd0,  16'h1234});

    i_rst_n     = 1'b0;
    i_rx        = 1'b1;
    i_reload    = 1'b0;
    en_read     = 1'b0;
    i_addr_read = '0;
    tick(3);
    check("reset_outputs",
          {7'd0, o_instr_read, o_load_done, o_max_addr, o_word_count, o_overflow, o_frame_err}, 32'd0);
    i_rst_n = 1'b1;
    tick(5);

    // Two full words, then the idle timeout.
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_done("t1_done", n);
    check("t1_done_latency_in_range", {31'd0, (n >= 190 && n <= 210)}, 32'd1);
    check("t1_word_count", o_word_count, 2);
    check("t1_max_addr", o_max_addr, 1);
    check("t1_flags", {o_overflow, o_frame_err}, 0);
    apply_reads(1);

    // Odd byte count: the last word is zero-padded at timeout.
    pulse_reload();
    check("t3_reload_clears_done", o_load_done, 0);
    check("t3_reload_clears_count", o_word_count, 0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_done("t3_done", n);
    check("t3_word_count", o_word_count, 2);
    check("t3_max_addr", o_max_addr, 1);
    apply_reads(3);

    // 17 words into a 16-deep memory.
    pulse_reload();
    for (int j = 0; j < 34; j++) send_byte(8'(j), 1'b1);
    wait_done("t4_done", n);
    check("t4_word_count", o_word_count, 16);
    check("t4_max_addr", o_max_addr, 15);
    check("t4_overflow", o_overflow, 1);
    apply_reads(4);

    // Glitch rejection, then a framing error followed by a good pair.
    pulse_reload();
    check("t5_reload_clears_overflow", o_overflow, 0);
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(150);
    check("t5_glitch_no_err", o_frame_err, 0);
    check("t5_glitch_no_load", {o_load_done, o_word_count}, 0);
    send_byte(8'h55, 1'b0);
    tick(20);
    check("t5_frame_err_set", o_frame_err, 1);
    check("t5_bad_byte_dropped", {o_load_done, o_word_count}, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_done("t5_done", n);
    check("t5_word_count", o_word_count, 1);
    check("t5_frame_err_sticky", o_frame_err, 1);
    apply_reads(5);

    // Reload from DONE, fresh word over old memory.
    pulse_reload();
    check("t6_reload_done_low", o_load_done, 0);
    check("t6_reload_flags", {o_overflow, o_frame_err}, 0);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    wait_done("t6_done", n);
    check("t6_word_count", o_word_count, 1);
    check("t6_max_addr", o_max_addr, 0);
    apply_reads(6);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h00, 1'b1);
    i_rx = 1'b0;
    tick(10);
    i_rx = 1'b1;
    tick(10);
    i_rx = 1'b0;
    tick(10);
    i_rst_n = 1'b0;
    #1;
    check("t6_async_reset_read", o_instr_read, 0);
    check("t6_async_reset_status",
          {o_load_done, o_max_addr, o_word_count, o_overflow, o_frame_err}, 0);
    @(negedge clk);
    i_rx = 1'b1;
    tick(3);
    i_rst_n = 1'b1;
    tick(20);
    check("t6_after_reset_idle", {o_load_done, o_word_count, o_frame_err}, 0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_done("t7_done", n);
    check("t7_word_count", o_word_count, 1);
    apply_reads(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
